// File: rtl/fht_wr_control_if.sv
// fht_wr_control_if
//   Bundles the stage-control inputs and the bank-RAM write-port outputs of
//   fht_wr_control.
//   master : the read-side controller side (drives iSTART/iSTAGE_GO/iSTAGE/
//            iSOURCE_DATA, observes write outputs)
//   slave  : fht_wr_control itself
//   Signals:
//     iSTART         FHT start pulse, aborts activity
//     iSTAGE_GO      one-cycle strobe on the first read cycle of a stage
//     iSTAGE[3:0]    stage index, sampled with iSTAGE_GO
//     iSOURCE_DATA   RAM set read this stage (0 = A), sampled with iSTAGE_GO
//     oADDR_WR       primary write address
//     oADDR_WR_BIAS  paired write address
//     oADDR_COEF     coefficient ROM address
//     oWE_A / oWE_B  write enables for RAM set A / B
//     oBUSY          stage write sequence in progress
//     oDONE          pulse after the last write of the final stage
//     oOVERRUN       sticky: stage strobe arrived while busy
interface fht_wr_control_if #(
  parameter int A_BIT = 8
);
  logic             iSTART;
  logic             iSTAGE_GO;
  logic [3:0]       iSTAGE;
  logic             iSOURCE_DATA;
  logic [A_BIT-1:0] oADDR_WR;
  logic [A_BIT-1:0] oADDR_WR_BIAS;
  logic [A_BIT-1:0] oADDR_COEF;
  logic             oWE_A;
  logic             oWE_B;
  logic             oBUSY;
  logic             oDONE;
  logic             oOVERRUN;

  modport master (
    output iSTART, iSTAGE_GO, iSTAGE, iSOURCE_DATA,
    input  oADDR_WR, oADDR_WR_BIAS, oADDR_COEF, oWE_A, oWE_B,
           oBUSY, oDONE, oOVERRUN
  );

  modport slave (
    input  iSTART, iSTAGE_GO, iSTAGE, iSOURCE_DATA,
    output oADDR_WR, oADDR_WR_BIAS, oADDR_COEF, oWE_A, oWE_B,
           oBUSY, oDONE, oOVERRUN
  );
endinterface

// File: rtl/fht_wr_control.sv
// fht_wr_control
//   Write-side address / write-enable generator for the FHT core. Each
//   iSTAGE_GO replays the stage's 2^A_BIT butterfly slots (2 cycles each),
//   delayed by the butterfly latency LAT, driving primary, bias and
//   coefficient addresses plus per-set write enables.
//   Ports:
//     iCLK    clock
//     iRESET  asynchronous active-low reset
//     bus     fht_wr_control_if.slave (stage control in, write port out)
//   Parameters:
//     A_BIT   bank address width
//     LAT     read-slot to write-slot latency, 1..6
//     LAST_ST index of the final stage
module fht_wr_control #(
  parameter int A_BIT   = 8,
  parameter int LAT     = 4,
  parameter int LAST_ST = 10
) (
  input  logic                iCLK,
  input  logic                iRESET,
  fht_wr_control_if.slave     bus
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_WRITE} state_t;

  localparam logic [2:0] DLY_LAST = 3'((LAT > 1) ? (LAT - 2) : 0);
  localparam logic [3:0] LAST_K   = 4'(LAST_ST);

  state_t           r_state;
  logic [2:0]       r_dly;
  logic             r_phase;
  logic [A_BIT-1:0] r_j;
  logic [3:0]       r_stage;
  logic             r_src;
  logic [A_BIT-1:0] r_bias;
  logic [A_BIT-1:0] r_coef;
  logic             r_we_a;
  logic             r_we_b;
  logic             r_busy;
  logic             r_done;
  logic             r_overrun;

  // Paired address: invert bit (A_BIT-k) for the middle stages.
  function automatic logic [A_BIT-1:0] bias_f(input logic [A_BIT-1:0] j,
                                               input logic [3:0] k);
    int kk;
    kk = int'(k);
    if (kk >= 1 && kk <= A_BIT && kk != LAST_ST)
      bias_f = j ^ (A_BIT'(1) << (A_BIT - kk));
    else
      bias_f = j;
  endfunction

  // (j mod 2^(A_BIT-k+1)) << (k-1) truncated equals j << (k-1) truncated,
  // since the bits removed by the modulo are exactly the ones shifted out.
  function automatic logic [A_BIT-1:0] coef_f(input logic [A_BIT-1:0] j,
                                               input logic [3:0] k);
    int kk;
    kk = int'(k);
    if (kk >= 1 && kk <= A_BIT)
      coef_f = j << (kk - 1);
    else
      coef_f = '0;
  endfunction

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_state   <= S_IDLE;
      r_dly     <= '0;
      r_phase   <= 1'b0;
      r_j       <= '0;
      r_stage   <= '0;
      r_src     <= 1'b0;
      r_bias    <= '0;
      r_coef    <= '0;
      r_we_a    <= 1'b0;
      r_we_b    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (bus.iSTART) begin
      r_state   <= S_IDLE;
      r_dly     <= '0;
      r_phase   <= 1'b0;
      r_j       <= '0;
      r_bias    <= bias_f('0, r_stage);
      r_coef    <= coef_f('0, r_stage);
      r_we_a    <= 1'b0;
      r_we_b    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (bus.iSTAGE_GO) begin
      // A strobe while busy abandons the current stage and restarts at slot 0.
      if (r_state != S_IDLE)
        r_overrun <= 1'b1;
      r_stage <= bus.iSTAGE;
      r_src   <= bus.iSOURCE_DATA;
      r_j     <= '0;
      r_bias  <= bias_f('0, bus.iSTAGE);
      r_coef  <= coef_f('0, bus.iSTAGE);
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_phase <= 1'b0;
      r_dly   <= '0;
      if (LAT == 1) begin
        r_state <= S_WRITE;
        r_we_a  <= bus.iSOURCE_DATA;
        r_we_b  <= ~bus.iSOURCE_DATA;
      end else begin
        r_state <= S_DELAY;
        r_we_a  <= 1'b0;
        r_we_b  <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_we_a <= 1'b0;
          r_we_b <= 1'b0;
          r_done <= 1'b0;
        end
        S_DELAY: begin
          if (r_dly == DLY_LAST) begin
            r_state <= S_WRITE;
            r_phase <= 1'b0;
            r_we_a  <= r_src;
            r_we_b  <= ~r_src;
          end else begin
            r_dly <= r_dly + 3'd1;
          end
        end
        S_WRITE: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
            r_we_a  <= 1'b0;
            r_we_b  <= 1'b0;
            if (r_j == '1 && r_stage == LAST_K)
              r_done <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            r_done  <= 1'b0;
            if (r_j == '1) begin
              // Addresses stay on the last slot until the next strobe.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_j    <= r_j + A_BIT'(1);
              r_bias <= bias_f(r_j + A_BIT'(1), r_stage);
              r_coef <= coef_f(r_j + A_BIT'(1), r_stage);
              r_we_a <= r_src;
              r_we_b <= ~r_src;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oADDR_WR      = r_j;
  assign bus.oADDR_WR_BIAS = r_bias;
  assign bus.oADDR_COEF    = r_coef;
  assign bus.oWE_A         = r_we_a;
  assign bus.oWE_B         = r_we_b;
  assign bus.oBUSY         = r_busy;
  assign bus.oDONE         = r_done;
  assign bus.oOVERRUN      = r_overrun;

endmodule

// File: tb/tb_fht_wr_control.sv
// tb_fht_wr_control
//   Scoreboard bench for fht_wr_control (A_BIT=8, LAT=4, LAST_ST=10).
//   Stimulus pushes the expected write slots and done pulses into queues; a
//   negedge monitor pops and compares whenever a write enable or oDONE shows.
module tb_fht_wr_control;

  localparam int LAT  = 4;
  localparam int LAST = 10;

  typedef struct {
    int cyc;
    int addr;
    int bias;
    int coef;
    int wa;
    int wb;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;

  wr_t wr_q[$];
  int  done_q[$];

  fht_wr_control_if #(.A_BIT(8)) bus ();

  fht_wr_control #(.A_BIT(8), .LAT(LAT), .LAST_ST(LAST)) dut (
    .iCLK   (clk),
    .iRESET (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model written from the stage formulas (div / mod form).
  function automatic int m_bias(input int j, input int k);
    if (k >= 1 && k <= 8 && k != LAST) return j ^ (1 << (8 - k));
    return j;
  endfunction

  function automatic int m_coef(input int j, input int k);
    int dv;
    int p;
    if (k == 0 || k >= 9) return 0;
    dv = 256 >> (k - 1);
    p  = j % dv;
    return (p << (k - 1)) % 256;
  endfunction

  task automatic push_stage(input int t, input int k, input int src);
    wr_t e;
    for (int i = 0; i < 256; i++) begin
      e.cyc  = t + LAT + 2 * i;
      e.addr = i;
      e.bias = m_bias(i, k);
      e.coef = m_coef(i, k);
      e.wa   = src;
      e.wb   = 1 - src;
      wr_q.push_back(e);
    end
    if (k == LAST) done_q.push_back(t + LAT + 511);
  endtask

  // Monitor: decoupled from stimulus, compares every presented write/done.
  always @(negedge clk) begin
    wr_t e;
    int  dc;
    if (bus.oWE_A || bus.oWE_B) begin
      n_writes++;
      check("write_expected", int'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_addr", int'(bus.oADDR_WR), e.addr);
        check("wr_bias", int'(bus.oADDR_WR_BIAS), e.bias);
        check("wr_coef", int'(bus.oADDR_COEF), e.coef);
        check("wr_we_a", int'(bus.oWE_A), e.wa);
        check("wr_we_b", int'(bus.oWE_B), e.wb);
      end
    end
    if (bus.oDONE) begin
      check("done_expected", int'(done_q.size() != 0), 1);
      if (done_q.size() != 0) begin
        dc = done_q.pop_front();
        check("done_cycle", cyc, dc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int k, input int src, input bit flush, output int t);
    bus.iSTAGE_GO    = 1'b1;
    bus.iSTAGE       = 4'(k);
    bus.iSOURCE_DATA = src[0];
    t = cyc;
    step();
    bus.iSTAGE_GO = 1'b0;
    if (flush) begin
      wr_q.delete();
      done_q.delete();
    end
    push_stage(t, k, src);
  endtask

  task automatic finish_stage(input int t);
    while (cyc < t + LAT + 511) step();
    check("busy_last_slot", int'(bus.oBUSY), 1);
    step();
    check("busy_fall", int'(bus.oBUSY), 0);
    check("done_low_after", int'(bus.oDONE), 0);
    check("writes_all_seen", wr_q.size(), 0);
    check("done_all_seen", done_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, int'(bus.oADDR_WR), 0);
    check({tag, "_bias"}, int'(bus.oADDR_WR_BIAS), 0);
    check({tag, "_coef"}, int'(bus.oADDR_COEF), 0);
    check({tag, "_we_a"}, int'(bus.oWE_A), 0);
    check({tag, "_we_b"}, int'(bus.oWE_B), 0);
    check({tag, "_busy"}, int'(bus.oBUSY), 0);
    check({tag, "_done"}, int'(bus.oDONE), 0);
    check({tag, "_ovr"},  int'(bus.oOVERRUN), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int x;
    int w0;
    bus.iSTART       = 1'b0;
    bus.iSTAGE_GO    = 1'b0;
    bus.iSTAGE       = '0;
    bus.iSOURCE_DATA = 1'b0;

    // Reset state.
    #2;
    check_all_zero("rst");
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check_all_zero("post_rst");

    // Stage 0, set A read -> writes to B, slots at cycles 14..524.
    while (cyc < 10) step();
    go(0, 0, 0, t);
    check("busy_rise", int'(bus.oBUSY), 1);
    finish_stage(t);

    // Stage 3, set B read -> writes to A; hand-computed slot values.
    repeat (5) step();
    go(3, 1, 0, t);
    while (cyc < t + LAT + 10) step();
    check("s3_slot5_addr", int'(bus.oADDR_WR), 5);
    check("s3_slot5_bias", int'(bus.oADDR_WR_BIAS), 37);
    check("s3_slot5_coef", int'(bus.oADDR_COEF), 20);
    check("s3_slot5_we_a", int'(bus.oWE_A), 1);
    while (cyc < t + LAT + 140) step();
    check("s3_slot70_addr", int'(bus.oADDR_WR), 70);
    check("s3_slot70_bias", int'(bus.oADDR_WR_BIAS), 102);
    check("s3_slot70_coef", int'(bus.oADDR_COEF), 24);
    finish_stage(t);

    // Final stage: single done pulse at t+515.
    repeat (3) step();
    go(LAST, 0, 0, t);
    finish_stage(t);

    // Overrun at slot 100, restart, then iSTART clears.
    repeat (4) step();
    go(5, 0, 0, t);
    x = t + LAT + 200;
    while (cyc < x) step();
    go(2, 1, 1, t);
    check("ovr_set", int'(bus.oOVERRUN), 1);
    check("ovr_restart_we_a", int'(bus.oWE_A), 0);
    check("ovr_restart_we_b", int'(bus.oWE_B), 0);
    check("ovr_busy", int'(bus.oBUSY), 1);
    while (cyc < x + 45) step();
    bus.iSTART = 1'b1;
    wr_q.delete();
    done_q.delete();
    step();
    bus.iSTART = 1'b0;
    check("start_ovr_clr", int'(bus.oOVERRUN), 0);
    check("start_busy", int'(bus.oBUSY), 0);
    check("start_addr", int'(bus.oADDR_WR), 0);
    check("start_we", int'(bus.oWE_A | bus.oWE_B), 0);
    repeat (20) step();

    // Eleven back-to-back stages, 518 cycles apart, alternating sets.
    for (int s = 0; s < 11; s++) begin
      go(s, s % 2, 0, t);
      if (s < 10) while (cyc < t + 518) step();
    end
    finish_stage(t);
    check("b2b_no_overrun", int'(bus.oOVERRUN), 0);

    // Reset mid-stage at slot 50: outputs drop at once, no writes after.
    repeat (3) step();
    go(4, 1, 0, t);
    while (cyc < t + LAT + 100) step();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    wr_q.delete();
    done_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    w0 = n_writes;
    repeat (600) step();
    check("no_write_after_reset", n_writes - w0, 0);
    check("idle_after_reset", int'(bus.oBUSY), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
